// File: rtl/go_pkg.sv
// Shared types for the 9x9 Go move path: move encoding, move source and
// sequencer state, plus the on-board range check.
package go_pkg;

    localparam int BOARD_N = 9;
    localparam logic [3:0] BOARD_MAX = 4'(BOARD_N - 1);

    typedef struct packed {
        logic [3:0] row;
        logic [3:0] col;
    } move_t;

    typedef enum logic {
        LOCAL  = 1'b0,
        REMOTE = 1'b1
    } src_t;

    typedef enum logic [4:0] {
        IDLE     = 5'b00001,
        CHECK    = 5'b00010,
        WAIT_UPD = 5'b00100,
        COMMIT   = 5'b01000,
        TX       = 5'b10000
    } seq_state_t;

    function automatic logic is_on_board(input move_t m);
        return (m.row <= BOARD_MAX) && (m.col <= BOARD_MAX);
    endfunction

endpackage

// File: rtl/move_sequencer.sv
// Admits one move at a time from the side to move, range-checks it, drives the
// shared board_updater, waits for verdict and turn flip, then forwards local moves to UART.
module move_sequencer
    import go_pkg::*;
#(
    parameter int UPD_TIMEOUT = 64,
    parameter int CNT_W       = 8
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             my_color,
    input  logic             turn,
    input  logic             local_valid,
    input  logic [7:0]       local_move,
    input  logic             remote_valid,
    input  logic [7:0]       remote_move,
    output logic             upd_start,
    output logic [7:0]       upd_move,
    input  logic             upd_valid,
    input  logic             upd_invalid,
    input  logic             tx_busy,
    output logic             tx_start,
    output logic [7:0]       tx_move,
    output logic             local_ack,
    output logic             local_reject,
    output logic             remote_nack,
    output logic             timeout_err,
    output logic             protocol_err,
    output logic [CNT_W-1:0] move_count
);

    localparam int TMR_W = $clog2(UPD_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(UPD_TIMEOUT);

    seq_state_t       state_q, state_d;
    move_t            cur_q, cur_d;
    src_t             src_q, src_d;
    logic             turn_lat_q, turn_lat_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    move_t            rbuf_q, rbuf_d;
    logic             rbuf_full_q, rbuf_full_d;
    logic [CNT_W-1:0] move_count_q, move_count_d;
    logic             timeout_err_q, timeout_err_d;
    logic             protocol_err_q, protocol_err_d;
    logic             upd_start_q, upd_start_d;
    logic             tx_start_q, tx_start_d;
    logic [7:0]       tx_move_q, tx_move_d;
    logic             local_ack_q, local_ack_d;
    logic             local_reject_q, local_reject_d;
    logic             remote_nack_q, remote_nack_d;

    logic local_owns;
    logic rbuf_take;
    logic reject_now;

    assign local_owns = (turn == my_color);

    always_comb begin
        // NOTE: every _d takes a default first so no path through the case infers a latch.
        state_d        = state_q;
        cur_d          = cur_q;
        src_d          = src_q;
        turn_lat_d     = turn_lat_q;
        timer_d        = timer_q;
        rbuf_d         = rbuf_q;
        rbuf_full_d    = rbuf_full_q;
        move_count_d   = move_count_q;
        timeout_err_d  = timeout_err_q;
        protocol_err_d = protocol_err_q;
        tx_move_d      = tx_move_q;
        upd_start_d    = 1'b0;
        tx_start_d     = 1'b0;
        local_ack_d    = 1'b0;
        local_reject_d = 1'b0;
        remote_nack_d  = 1'b0;
        rbuf_take      = 1'b0;
        reject_now     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (local_owns) begin
                    if (local_valid) begin
                        cur_d   = move_t'(local_move);
                        src_d   = LOCAL;
                        state_d = CHECK;
                    end
                end else begin
                    if (rbuf_full_q) begin
                        cur_d     = rbuf_q;
                        rbuf_take = 1'b1;
                        src_d     = REMOTE;
                        state_d   = CHECK;
                    end
                    if (local_valid) local_reject_d = 1'b1;
                end
            end
            CHECK: begin
                turn_lat_d = turn;
                if (!is_on_board(cur_q)) begin
                    reject_now = 1'b1;
                    state_d    = IDLE;
                end else begin
                    upd_start_d = 1'b1;
                    timer_d     = '0;
                    state_d     = WAIT_UPD;
                end
            end
            WAIT_UPD: begin
                timer_d = timer_q + 1'b1;
                // A simultaneous valid/invalid is resolved as a rejection.
                if (upd_invalid) begin
                    reject_now = 1'b1;
                    state_d    = IDLE;
                end else if (upd_valid) begin
                    timer_d = '0;
                    state_d = COMMIT;
                end else if (timer_q == TMR_MAX) begin
                    timeout_err_d = 1'b1;
                    reject_now    = 1'b1;
                    state_d       = IDLE;
                end
            end
            COMMIT: begin
                timer_d = timer_q + 1'b1;
                if (turn != turn_lat_q) begin
                    if (move_count_q != '1) move_count_d = move_count_q + 1'b1;
                    timer_d = '0;
                    state_d = (src_q == LOCAL) ? TX : IDLE;
                end else if (timer_q == TMR_MAX) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            TX: begin
                if (!tx_busy) begin
                    tx_start_d  = 1'b1;
                    tx_move_d   = cur_q;
                    local_ack_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (reject_now) begin
            if (src_q == LOCAL) local_reject_d = 1'b1;
            else                remote_nack_d  = 1'b1;
        end

        // The buffer is judged on its registered fullness, so a pulse landing
        // on the same edge the entry is drained is still dropped.
        if (rbuf_take) rbuf_full_d = 1'b0;
        if (remote_valid) begin
            if (!rbuf_full_q && !local_owns) begin
                rbuf_d      = move_t'(remote_move);
                rbuf_full_d = 1'b1;
            end else begin
                protocol_err_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q        <= IDLE;
            cur_q          <= '0;
            src_q          <= LOCAL;
            turn_lat_q     <= 1'b0;
            timer_q        <= '0;
            rbuf_q         <= '0;
            rbuf_full_q    <= 1'b0;
            move_count_q   <= '0;
            timeout_err_q  <= 1'b0;
            protocol_err_q <= 1'b0;
            upd_start_q    <= 1'b0;
            tx_start_q     <= 1'b0;
            tx_move_q      <= '0;
            local_ack_q    <= 1'b0;
            local_reject_q <= 1'b0;
            remote_nack_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_q          <= cur_d;
            src_q          <= src_d;
            turn_lat_q     <= turn_lat_d;
            timer_q        <= timer_d;
            rbuf_q         <= rbuf_d;
            rbuf_full_q    <= rbuf_full_d;
            move_count_q   <= move_count_d;
            timeout_err_q  <= timeout_err_d;
            protocol_err_q <= protocol_err_d;
            upd_start_q    <= upd_start_d;
            tx_start_q     <= tx_start_d;
            tx_move_q      <= tx_move_d;
            local_ack_q    <= local_ack_d;
            local_reject_q <= local_reject_d;
            remote_nack_q  <= remote_nack_d;
        end
    end

    // Pulses are masked by reset so none overlaps the cycle reset is raised in.
    assign upd_start    = upd_start_q    & ~reset;
    assign tx_start     = tx_start_q     & ~reset;
    assign local_ack    = local_ack_q    & ~reset;
    assign local_reject = local_reject_q & ~reset;
    assign remote_nack  = remote_nack_q  & ~reset;

    assign upd_move     = (state_q == CHECK || state_q == WAIT_UPD) ? cur_q : 8'h00;
    assign tx_move      = tx_move_q;
    assign timeout_err  = timeout_err_q;
    assign protocol_err = protocol_err_q;
    assign move_count   = move_count_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: inputs change 1 time unit after each rising
// edge and outputs are checked at that point, so cycle n is the span after edge n.
module tb_move_sequencer;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       my_color;
    logic       turn;
    logic       local_valid;
    logic [7:0] local_move;
    logic       remote_valid;
    logic [7:0] remote_move;
    logic       upd_start;
    logic [7:0] upd_move;
    logic       upd_valid;
    logic       upd_invalid;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_move;
    logic       local_ack;
    logic       local_reject;
    logic       remote_nack;
    logic       timeout_err;
    logic       protocol_err;
    logic [7:0] move_count;

    int checks = 0;
    int errors = 0;

    move_sequencer #(.UPD_TIMEOUT(64), .CNT_W(8)) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .my_color     (my_color),
        .turn         (turn),
        .local_valid  (local_valid),
        .local_move   (local_move),
        .remote_valid (remote_valid),
        .remote_move  (remote_move),
        .upd_start    (upd_start),
        .upd_move     (upd_move),
        .upd_valid    (upd_valid),
        .upd_invalid  (upd_invalid),
        .tx_busy      (tx_busy),
        .tx_start     (tx_start),
        .tx_move      (tx_move),
        .local_ack    (local_ack),
        .local_reject (local_reject),
        .remote_nack  (remote_nack),
        .timeout_err  (timeout_err),
        .protocol_err (protocol_err),
        .move_count   (move_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_upd_start"},    upd_start,    0);
        check({tag, "_tx_start"},     tx_start,     0);
        check({tag, "_local_ack"},    local_ack,    0);
        check({tag, "_local_reject"}, local_reject, 0);
        check({tag, "_remote_nack"},  remote_nack,  0);
    endtask

    logic [7:0] bad_moves [2];

    initial begin
        bad_moves[0] = 8'h39;
        bad_moves[1] = 8'h93;

        reset = 1'b1; my_color = 1'b0; turn = 1'b0;
        local_valid = 1'b0; local_move = 8'h00;
        remote_valid = 1'b0; remote_move = 8'h00;
        upd_valid = 1'b0; upd_invalid = 1'b0; tx_busy = 1'b0;

        // Reset state
        tick(2);
        check_quiet("rst");
        check("rst_upd_move", upd_move, 8'h00);
        check("rst_tx_move", tx_move, 8'h00);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_protocol_err", protocol_err, 0);
        check("rst_move_count", move_count, 0);
        reset = 1'b0;
        tick();

        // Local legal move 0x34, verdict 3 cycles after upd_start, turn flips at k+2
        local_move = 8'h34; local_valid = 1'b1;
        tick();                                        // c1
        local_valid = 1'b0;
        check("s1_c1_upd_start", upd_start, 0);
        tick();                                        // c2
        check("s1_c2_upd_start", upd_start, 1);
        check("s1_c2_upd_move", upd_move, 8'h34);
        tick();                                        // c3
        check("s1_c3_upd_start", upd_start, 0);
        tick(2);                                       // c5
        upd_valid = 1'b1;
        tick();                                        // c6
        upd_valid = 1'b0;
        tick();                                        // c7
        turn = 1'b1;
        tick();                                        // c8
        check("s1_c8_tx_start", tx_start, 0);
        tick();                                        // c9
        check("s1_c9_tx_start", tx_start, 1);
        check("s1_c9_tx_move", tx_move, 8'h34);
        check("s1_c9_local_ack", local_ack, 1);
        check("s1_c9_move_count", move_count, 1);
        tick();                                        // c10
        check("s1_c10_tx_start", tx_start, 0);
        check("s1_c10_local_ack", local_ack, 0);

        // Remote 0x00 rejected by the updater
        remote_move = 8'h00; remote_valid = 1'b1;
        tick();                                        // c1
        remote_valid = 1'b0;
        tick(2);                                       // c3
        check("rj_c3_upd_start", upd_start, 1);
        check("rj_c3_upd_move", upd_move, 8'h00);
        tick(3);                                       // c6
        upd_invalid = 1'b1;
        tick();                                        // c7
        upd_invalid = 1'b0;
        check("rj_c7_remote_nack", remote_nack, 1);
        check("rj_c7_local_reject", local_reject, 0);
        check("rj_c7_tx_start", tx_start, 0);
        check("rj_c7_move_count", move_count, 1);
        tick();                                        // c8
        check("rj_c8_remote_nack", remote_nack, 0);

        // Local request while remote owns the move
        local_move = 8'h34; local_valid = 1'b1;
        tick();                                        // c1
        local_valid = 1'b0;
        check("oot_c1_local_reject", local_reject, 1);
        check("oot_c1_upd_start", upd_start, 0);
        tick();                                        // c2
        check("oot_c2_local_reject", local_reject, 0);

        // Out-of-range local moves: reject in cycle 2, updater untouched
        for (int i = 0; i < 2; i++) begin
            turn = 1'b0; local_move = bad_moves[i]; local_valid = 1'b1;
            tick();                                    // c1
            local_valid = 1'b0;
            check("oor_c1_upd_start", upd_start, 0);
            tick();                                    // c2
            check("oor_c2_local_reject", local_reject, 1);
            check("oor_c2_upd_start", upd_start, 0);
            tick();                                    // c3
            check("oor_c3_local_reject", local_reject, 0);
            check("oor_c3_upd_start", upd_start, 0);
        end

        // Corner move 0x88 with a silent updater: timer hits 64 in cycle 66
        local_move = 8'h88; local_valid = 1'b1;
        tick();                                        // c1
        local_valid = 1'b0;
        tick();                                        // c2
        check("to_c2_upd_start", upd_start, 1);
        check("to_c2_upd_move", upd_move, 8'h88);
        tick(64);                                      // c66
        check("to_c66_timeout_err", timeout_err, 0);
        check("to_c66_local_reject", local_reject, 0);
        check("to_c66_upd_move", upd_move, 8'h88);
        tick();                                        // c67
        check("to_c67_timeout_err", timeout_err, 1);
        check("to_c67_local_reject", local_reject, 1);
        check("to_c67_upd_move", upd_move, 8'h00);
        tick();                                        // c68
        check("to_c68_local_reject", local_reject, 0);
        check("to_c68_timeout_sticky", timeout_err, 1);

        // Remote 0x12 in flight; 0x45 buffered, 0x67 overflows the buffer
        turn = 1'b1; remote_move = 8'h12; remote_valid = 1'b1;
        tick();                                        // c1
        remote_valid = 1'b0;
        tick(2);                                       // c3
        check("pe_c3_upd_start", upd_start, 1);
        check("pe_c3_upd_move", upd_move, 8'h12);
        tick();                                        // c4
        remote_move = 8'h45; remote_valid = 1'b1;
        tick();                                        // c5
        remote_valid = 1'b0;
        tick();                                        // c6
        remote_move = 8'h67; remote_valid = 1'b1;
        check("pe_c6_protocol_err", protocol_err, 0);
        tick();                                        // c7
        remote_valid = 1'b0;
        check("pe_c7_protocol_err", protocol_err, 1);
        upd_invalid = 1'b1;
        tick();                                        // c8
        upd_invalid = 1'b0;
        check("pe_c8_remote_nack", remote_nack, 1);
        tick(2);                                       // c10
        check("pe_c10_upd_start", upd_start, 1);
        check("pe_c10_upd_move", upd_move, 8'h45);
        tick();                                        // c11
        upd_valid = 1'b1;
        tick();                                        // c12
        upd_valid = 1'b0;
        turn = 1'b0;
        tick();                                        // c13
        check("pe_c13_move_count", move_count, 2);
        check("pe_c13_tx_start", tx_start, 0);
        check("pe_c13_local_ack", local_ack, 0);
        tick();                                        // c14
        check_quiet("pe_c14");

        // Local 0x00 with the transmitter busy for 10 cycles in TX
        tx_busy = 1'b1; local_move = 8'h00; local_valid = 1'b1;
        tick();                                        // c1
        local_valid = 1'b0;
        tick();                                        // c2
        check("bp_c2_upd_start", upd_start, 1);
        check("bp_c2_upd_move", upd_move, 8'h00);
        tick(3);                                       // c5
        upd_valid = 1'b1;
        tick();                                        // c6
        upd_valid = 1'b0;
        tick();                                        // c7
        turn = 1'b1;
        tick();                                        // c8
        tick(10);                                      // c18
        check("bp_c18_tx_start", tx_start, 0);
        check("bp_c18_local_ack", local_ack, 0);
        tx_busy = 1'b0;
        tick();                                        // c19
        check("bp_c19_tx_start", tx_start, 1);
        check("bp_c19_tx_move", tx_move, 8'h00);
        check("bp_c19_local_ack", local_ack, 1);
        check("bp_c19_move_count", move_count, 3);
        tick();                                        // c20
        check("bp_c20_tx_start", tx_start, 0);

        // Reset while waiting on the updater
        remote_move = 8'h22; remote_valid = 1'b1;
        tick();                                        // c1
        remote_valid = 1'b0;
        tick(2);                                       // c3
        check("mr_c3_upd_start", upd_start, 1);
        tick();                                        // c4
        reset = 1'b1;
        tick();                                        // c5
        check_quiet("mr_c5");
        check("mr_c5_upd_move", upd_move, 8'h00);
        check("mr_c5_tx_move", tx_move, 8'h00);
        check("mr_c5_timeout_err", timeout_err, 0);
        check("mr_c5_protocol_err", protocol_err, 0);
        check("mr_c5_move_count", move_count, 0);
        reset = 1'b0;
        tick();                                        // c6
        remote_move = 8'h56; remote_valid = 1'b1;
        tick();                                        // c7
        remote_valid = 1'b0;
        tick(2);                                       // c9
        check("mr_c9_upd_start", upd_start, 1);
        check("mr_c9_upd_move", upd_move, 8'h56);
        upd_invalid = 1'b1;
        tick();                                        // c10
        upd_invalid = 1'b0;
        check("mr_c10_remote_nack", remote_nack, 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
